// File: rtl/uart_st_pkg.sv
// Shared defaults for the UART Avalon-ST stream controller.
// Holds the default data width, FIFO depths, heartbeat period and heartbeat
// symbol, plus the enum that names the TX output register load source.
package uart_st_pkg;

    localparam int         DATA_W_DEF    = 8;
    localparam int         TX_DEPTH_DEF  = 16;
    localparam int         RX_DEPTH_DEF  = 16;
    localparam int         HB_PERIOD_DEF = 5_000_000;
    localparam logic [7:0] HB_CHAR_DEF   = 8'h41;

    // What the TX output register loads this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_FIFO = 2'd1,
        SRC_HB   = 2'd2
    } tx_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output.
// Ports:
//   clk, reset_n            clock, async active-low reset (clears pointers/level/storage)
//   push_i / push_data_i    write request and data; ignored while full
//   pop_i                   read request; ignored while empty
//   head_o                  oldest entry (valid whenever empty_o is 0)
//   empty_o / full_o        status flags
//   level_o                 number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_st_stream_ctrl.sv
// UART stream controller: bridges a host write/read stream pair to a UART
// Avalon-ST transmit sink / receive source, with optional RX->TX echo and a
// periodic heartbeat symbol.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   i_hb_en                               heartbeat enable
//   i_echo_en                             route received symbols to the TX FIFO
//   i_wr_data/i_wr_valid/o_wr_ready       host write stream into TX FIFO
//   o_rd_data/o_rd_valid/i_rd_ready       host read stream out of RX FIFO (show-ahead)
//   o_tx_data/o_tx_valid/i_tx_ready       stream source to UART transmitter
//   i_rx_data/i_rx_valid/o_rx_ready       stream sink from UART receiver
//   o_tx_level/o_rx_level                 FIFO occupancy
//   o_tx_cnt                              completed TX handshakes, wraps at 16 bits
module uart_st_stream_ctrl
    import uart_st_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                TX_DEPTH  = TX_DEPTH_DEF,
    parameter int                RX_DEPTH  = RX_DEPTH_DEF,
    parameter int                HB_PERIOD = HB_PERIOD_DEF,
    parameter logic [DATA_W-1:0] HB_CHAR   = DATA_W'(HB_CHAR_DEF)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_hb_en,
    input  logic                          i_echo_en,
    input  logic [DATA_W-1:0]             i_wr_data,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [DATA_W-1:0]             o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    input  logic [DATA_W-1:0]             i_rx_data,
    input  logic                          i_rx_valid,
    output logic                          o_rx_ready,
    output logic [$clog2(TX_DEPTH+1)-1:0] o_tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0] o_rx_level,
    output logic [15:0]                   o_tx_cnt
);

    localparam int             HB_CW     = (HB_PERIOD > 2) ? $clog2(HB_PERIOD) : 1;
    localparam logic [HB_CW-1:0] HB_RELOAD = HB_CW'(HB_PERIOD - 1);

    // Holds readies low until the first clock edge after reset release.
    logic              ready_en_q;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_W-1:0] tx_push_data;
    logic              wr_fire, rx_fire;

    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    tx_src_e           tx_src;
    logic              hb_load;

    logic [HB_CW-1:0]  hb_cnt_q, hb_cnt_d;
    logic              hb_pending_q, hb_pending_d;
    logic [15:0]       tx_cnt_q, tx_cnt_d;

    // Ready generation and write routing.
    assign o_wr_ready   = ready_en_q && !tx_full && !i_echo_en;
    assign o_rx_ready   = ready_en_q && (i_echo_en ? !tx_full : !rx_full);
    assign wr_fire      = i_wr_valid && o_wr_ready;
    assign rx_fire      = i_rx_valid && o_rx_ready;
    assign tx_push      = wr_fire || (rx_fire && i_echo_en);
    assign tx_push_data = i_echo_en ? i_rx_data : i_wr_data;
    assign rx_push      = rx_fire && !i_echo_en;
    assign o_rd_valid   = !rx_empty;
    assign rx_pop       = o_rd_valid && i_rd_ready;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (tx_push),
        .push_data_i (tx_push_data),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .empty_o     (tx_empty),
        .full_o      (tx_full),
        .level_o     (o_tx_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (rx_push),
        .push_data_i (i_rx_data),
        .pop_i       (rx_pop),
        .head_o      (o_rd_data),
        .empty_o     (rx_empty),
        .full_o      (rx_full),
        .level_o     (o_rx_level)
    );

    // TX output register: loads only when empty or being consumed, so a
    // presented symbol stays stable until its handshake. FIFO data wins over
    // a pending heartbeat.
    always_comb begin
        tx_src     = SRC_NONE;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (!tx_valid_q || i_tx_ready) begin
            if (!tx_empty) begin
                tx_src     = SRC_FIFO;
                tx_valid_d = 1'b1;
                tx_data_d  = tx_head;
            end else if (hb_pending_q) begin
                tx_src     = SRC_HB;
                tx_valid_d = 1'b1;
                tx_data_d  = HB_CHAR;
            end else begin
                tx_valid_d = 1'b0;
            end
        end
    end

    assign tx_pop  = (tx_src == SRC_FIFO);
    assign hb_load = (tx_src == SRC_HB);

    // Heartbeat down-counter; a tick while one is already pending is absorbed.
    always_comb begin
        hb_cnt_d     = hb_cnt_q;
        hb_pending_d = hb_pending_q && !hb_load;
        if (!i_hb_en) begin
            hb_cnt_d     = HB_RELOAD;
            hb_pending_d = 1'b0;
        end else if (hb_cnt_q == '0) begin
            hb_cnt_d     = HB_RELOAD;
            hb_pending_d = 1'b1;
        end else begin
            hb_cnt_d = hb_cnt_q - HB_CW'(1);
        end
    end

    assign tx_cnt_d = tx_cnt_q + {15'd0, (tx_valid_q && i_tx_ready)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            hb_cnt_q     <= HB_RELOAD;
            hb_pending_q <= 1'b0;
            tx_cnt_q     <= '0;
        end else begin
            ready_en_q   <= 1'b1;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            hb_cnt_q     <= hb_cnt_d;
            hb_pending_q <= hb_pending_d;
            tx_cnt_q     <= tx_cnt_d;
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_cnt   = tx_cnt_q;

endmodule
